// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the pipeline stages, the shared memory bus and mem_port_arbiter.
// The arbiter uses the slave view; the stages/bus environment uses the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              ireq_valid;
    logic [ADDR_W-1:0] ireq_addr;
    logic              iflush;
    logic              iresp_ok;
    logic [31:0]       iresp_data;

    logic              dreq_valid;
    logic [ADDR_W-1:0] dreq_addr;
    logic              dreq_write;
    logic [2:0]        dreq_size;
    logic [7:0]        dreq_strobe;
    logic [DATA_W-1:0] dreq_wdata;
    logic              dresp_ok;
    logic [DATA_W-1:0] dresp_data;

    logic              creq_valid;
    logic [ADDR_W-1:0] creq_addr;
    logic              creq_write;
    logic [2:0]        creq_size;
    logic [7:0]        creq_strobe;
    logic [DATA_W-1:0] creq_wdata;
    logic              cresp_ok;
    logic [DATA_W-1:0] cresp_data;

    logic              istall;
    logic              dstall;

    modport slave (
        input  ireq_valid, ireq_addr, iflush,
        input  dreq_valid, dreq_addr, dreq_write, dreq_size, dreq_strobe, dreq_wdata,
        input  cresp_ok, cresp_data,
        output iresp_ok, iresp_data, dresp_ok, dresp_data,
        output creq_valid, creq_addr, creq_write, creq_size, creq_strobe, creq_wdata,
        output istall, dstall
    );

    modport master (
        output ireq_valid, ireq_addr, iflush,
        output dreq_valid, dreq_addr, dreq_write, dreq_size, dreq_strobe, dreq_wdata,
        output cresp_ok, cresp_data,
        input  iresp_ok, iresp_data, dresp_ok, dresp_data,
        input  creq_valid, creq_addr, creq_write, creq_size, creq_strobe, creq_wdata,
        input  istall, dstall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter of the core's single memory port between fetch and memory stage.
// One transaction at a time: latch, hold on the bus until acked, pulse ok to the owner.
module mem_port_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                resetn,
    mem_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ_I = 2'd1,
        ST_REQ_D = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    // Instruction words are 4-byte aligned, so addr[2] picks the half of the bus word.
    function automatic logic [31:0] fetch_word(input logic hi_half, input logic [DATA_W-1:0] data);
        if (hi_half) begin
            fetch_word = data[63:32];
        end else begin
            fetch_word = data[31:0];
        end
    endfunction

    state_t            state_r;
    state_t            state_next_s;
    logic              last_grant_r;
    logic              drop_r;
    logic              ireq_eff_s;
    logic              grant_i_s;
    logic              grant_d_s;
    logic              ack_i_s;
    logic              ack_d_s;

    logic              creq_valid_r;
    logic [ADDR_W-1:0] creq_addr_r;
    logic              creq_write_r;
    logic [2:0]        creq_size_r;
    logic [7:0]        creq_strobe_r;
    logic [DATA_W-1:0] creq_wdata_r;
    logic              iresp_ok_r;
    logic [31:0]       iresp_data_r;
    logic              dresp_ok_r;
    logic [DATA_W-1:0] dresp_data_r;

    assign ireq_eff_s = bus.ireq_valid & ~bus.iflush;
    assign ack_i_s    = (state_r == ST_REQ_I) & bus.cresp_ok;
    assign ack_d_s    = (state_r == ST_REQ_D) & bus.cresp_ok;

    // Next-state and grant decode; on contention the side not served last wins.
    always_comb begin
        state_next_s = state_r;
        grant_i_s    = 1'b0;
        grant_d_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ireq_eff_s && bus.dreq_valid) begin
                    if (last_grant_r == GRANT_I) begin
                        grant_d_s = 1'b1;
                    end else begin
                        grant_i_s = 1'b1;
                    end
                end else if (ireq_eff_s) begin
                    grant_i_s = 1'b1;
                end else if (bus.dreq_valid) begin
                    grant_d_s = 1'b1;
                end else begin
                    grant_i_s = 1'b0;
                end
                if (grant_i_s) begin
                    state_next_s = ST_REQ_I;
                end else if (grant_d_s) begin
                    state_next_s = ST_REQ_D;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ_I, ST_REQ_D: begin
                if (bus.cresp_ok) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_RESP: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Shared-port request register: loaded on grant, held until the bus acknowledges.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            creq_valid_r  <= 1'b0;
            creq_addr_r   <= {ADDR_W{1'b0}};
            creq_write_r  <= 1'b0;
            creq_size_r   <= 3'd0;
            creq_strobe_r <= 8'd0;
            creq_wdata_r  <= {DATA_W{1'b0}};
            last_grant_r  <= GRANT_I;
        end else if (grant_i_s) begin
            creq_valid_r  <= 1'b1;
            creq_addr_r   <= bus.ireq_addr;
            creq_write_r  <= 1'b0;
            creq_size_r   <= 3'd2;
            creq_strobe_r <= 8'd0;
            creq_wdata_r  <= {DATA_W{1'b0}};
            last_grant_r  <= GRANT_I;
        end else if (grant_d_s) begin
            creq_valid_r  <= 1'b1;
            creq_addr_r   <= bus.dreq_addr;
            creq_write_r  <= bus.dreq_write;
            creq_size_r   <= bus.dreq_size;
            creq_strobe_r <= bus.dreq_strobe;
            creq_wdata_r  <= bus.dreq_wdata;
            last_grant_r  <= GRANT_D;
        end else if (ack_i_s || ack_d_s) begin
            creq_valid_r  <= 1'b0;
        end else begin
            creq_valid_r  <= creq_valid_r;
        end
    end

    // A flush seen during a fetch marks it stale; it still completes on the bus silently.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drop_r <= 1'b0;
        end else if ((state_r == ST_REQ_I) && bus.iflush) begin
            drop_r <= 1'b1;
        end else if (state_r == ST_RESP) begin
            drop_r <= 1'b0;
        end else begin
            drop_r <= drop_r;
        end
    end

    // Response capture; ok pulses land in the cycle after the acknowledge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            iresp_ok_r   <= 1'b0;
            iresp_data_r <= 32'd0;
            dresp_ok_r   <= 1'b0;
            dresp_data_r <= {DATA_W{1'b0}};
        end else begin
            iresp_ok_r <= ack_i_s & ~drop_r & ~bus.iflush;
            dresp_ok_r <= ack_d_s;
            if (ack_i_s) begin
                iresp_data_r <= fetch_word(creq_addr_r[2], bus.cresp_data);
            end else begin
                iresp_data_r <= iresp_data_r;
            end
            if (ack_d_s) begin
                dresp_data_r <= bus.cresp_data;
            end else begin
                dresp_data_r <= dresp_data_r;
            end
        end
    end

    assign bus.creq_valid  = creq_valid_r;
    assign bus.creq_addr   = creq_addr_r;
    assign bus.creq_write  = creq_write_r;
    assign bus.creq_size   = creq_size_r;
    assign bus.creq_strobe = creq_strobe_r;
    assign bus.creq_wdata  = creq_wdata_r;
    assign bus.iresp_ok    = iresp_ok_r;
    assign bus.iresp_data  = iresp_data_r;
    assign bus.dresp_ok    = dresp_ok_r;
    assign bus.dresp_data  = dresp_data_r;
    assign bus.istall      = bus.ireq_valid & ~iresp_ok_r & ~bus.iflush;
    assign bus.dstall      = bus.dreq_valid & ~dresp_ok_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a
// transaction-level model of grants, bus fields and ok pulses.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // stimulus for the next cycle
    logic        s_iv, s_fl, s_dv, s_dw, s_ack;
    logic [63:0] s_ia, s_da, s_dwd, s_adata;
    logic [2:0]  s_ds;
    logic [7:0]  s_dst;

    // transaction-level model: what is on the bus now, what ok is due this cycle
    logic        m_busy, m_resp, m_src_d, m_last_d, m_drop, m_iok, m_dok;
    logic [63:0] m_addr, m_wdata, m_ddata;
    logic        m_write;
    logic [2:0]  m_size;
    logic [7:0]  m_strobe;
    logic [31:0] m_idata;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_resp = 1'b0; m_src_d = 1'b0; m_last_d = 1'b0; m_drop = 1'b0;
        m_iok = 1'b0; m_dok = 1'b0; m_addr = 64'd0; m_wdata = 64'd0; m_ddata = 64'd0;
        m_write = 1'b0; m_size = 3'd0; m_strobe = 8'd0; m_idata = 32'd0;
    endtask

    task automatic clear_stim();
        s_iv = 1'b0; s_fl = 1'b0; s_dv = 1'b0; s_dw = 1'b0; s_ack = 1'b0;
        s_ia = 64'd0; s_da = 64'd0; s_dwd = 64'd0; s_adata = 64'd0; s_ds = 3'd0; s_dst = 8'd0;
    endtask

    // One clock cycle: check registered outputs, apply stimulus, check stalls, advance model.
    task automatic step();
        logic gi, gd, ni, nd;
        @(negedge clk);
        check_val("creq_valid", bus.creq_valid, m_busy);
        if (m_busy) begin
            check_val("creq_addr", bus.creq_addr, m_addr);
            check_val("creq_write", bus.creq_write, m_write);
            check_val("creq_size", bus.creq_size, m_size);
            check_val("creq_strobe", bus.creq_strobe, m_strobe);
            if (m_src_d) check_val("creq_wdata", bus.creq_wdata, m_wdata);
        end
        check_val("iresp_ok", bus.iresp_ok, m_iok);
        if (m_iok) check_val("iresp_data", bus.iresp_data, m_idata);
        check_val("dresp_ok", bus.dresp_ok, m_dok);
        if (m_dok) check_val("dresp_data", bus.dresp_data, m_ddata);

        bus.ireq_valid = s_iv;  bus.ireq_addr = s_ia;  bus.iflush = s_fl;
        bus.dreq_valid = s_dv;  bus.dreq_addr = s_da;  bus.dreq_write = s_dw;
        bus.dreq_size = s_ds;   bus.dreq_strobe = s_dst; bus.dreq_wdata = s_dwd;
        bus.cresp_ok = s_ack;   bus.cresp_data = s_adata;
        #1;
        check_val("istall", bus.istall, s_iv & ~m_iok & ~s_fl);
        check_val("dstall", bus.dstall, s_dv & ~m_dok);

        ni = 1'b0; nd = 1'b0;
        if (m_resp) begin
            m_resp = 1'b0;
        end else if (m_busy) begin
            if (s_ack) begin
                m_busy = 1'b0;
                m_resp = 1'b1;
                if (m_src_d) begin
                    nd = 1'b1;
                    m_ddata = s_adata;
                end else begin
                    ni = !(m_drop || s_fl);
                    m_idata = m_addr[2] ? s_adata[63:32] : s_adata[31:0];
                end
            end else if (!m_src_d && s_fl) begin
                m_drop = 1'b1;
            end
        end else begin
            gi = s_iv & ~s_fl;
            gd = s_dv;
            if (gi || gd) begin
                m_src_d  = (gi && gd) ? !m_last_d : gd;
                m_last_d = m_src_d;
                m_busy   = 1'b1;
                m_drop   = 1'b0;
                if (m_src_d) begin
                    m_addr = s_da; m_write = s_dw; m_size = s_ds; m_strobe = s_dst; m_wdata = s_dwd;
                end else begin
                    m_addr = s_ia; m_write = 1'b0; m_size = 3'd2; m_strobe = 8'd0;
                end
            end
        end
        m_iok = ni;
        m_dok = nd;
        s_ack = 1'b0;
        s_fl  = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic lat_on;
        clear_stim();
        model_reset();
        bus.ireq_valid = 1'b0; bus.ireq_addr = 64'd0; bus.iflush = 1'b0;
        bus.dreq_valid = 1'b0; bus.dreq_addr = 64'd0; bus.dreq_write = 1'b0;
        bus.dreq_size = 3'd0; bus.dreq_strobe = 8'd0; bus.dreq_wdata = 64'd0;
        bus.cresp_ok = 1'b0; bus.cresp_data = 64'd0;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_creq_valid", bus.creq_valid, 64'd0);
        check_val("rst_creq_addr", bus.creq_addr, 64'd0);
        check_val("rst_creq_fields", {bus.creq_write, bus.creq_size, bus.creq_strobe}, 64'd0);
        check_val("rst_creq_wdata", bus.creq_wdata, 64'd0);
        check_val("rst_oks", {bus.iresp_ok, bus.dresp_ok}, 64'd0);
        check_val("rst_iresp_data", bus.iresp_data, 64'd0);
        check_val("rst_dresp_data", bus.dresp_data, 64'd0);
        resetn = 1'b1;

        // contention straight after reset: D first, then I
        s_iv = 1'b1; s_ia = 64'h0000_0000_0000_1008;
        s_dv = 1'b1; s_da = 64'h0000_0000_0000_2010; s_ds = 3'd3; s_dst = 8'hFF;
        step();
        s_ack = 1'b1; s_adata = 64'h0123_4567_89AB_CDEF;
        step();
        check_val("contention_first_d", bus.creq_addr, 64'h0000_0000_0000_2010);
        step();
        check_val("contention_d_ok", bus.dresp_ok, 64'd1);
        s_dv = 1'b0;
        step();
        s_ack = 1'b1; s_adata = 64'hCAFE_0001_BEEF_0002;
        step();
        check_val("contention_then_i", bus.creq_addr, 64'h0000_0000_0000_1008);
        step();
        check_val("contention_i_ok", bus.iresp_ok, 64'd1);
        s_iv = 1'b0;
        step();

        // single fetch, acked one cycle after grant
        s_iv = 1'b1; s_ia = 64'h0000_0000_8000_0004;
        step();
        s_ack = 1'b1; s_adata = 64'h1111_2222_3333_4444;
        step();
        check_val("single_fetch_addr", bus.creq_addr, 64'h0000_0000_8000_0004);
        check_val("single_fetch_size", bus.creq_size, 64'd2);
        step();
        check_val("single_fetch_ok", bus.iresp_ok, 64'd1);
        check_val("single_fetch_data", bus.iresp_data, 64'h1111_2222);
        s_iv = 1'b0;
        step();

        // flush coincident with ack, waiting D granted in the next idle
        s_iv = 1'b1; s_ia = 64'h0000_0000_0000_4000;
        step();
        s_fl = 1'b1; s_ack = 1'b1; s_adata = 64'h5555_6666_7777_8888;
        s_dv = 1'b1; s_da = 64'h0000_0000_0000_3000; s_dw = 1'b0; s_ds = 3'd2; s_dst = 8'h0F;
        step();
        s_iv = 1'b0;
        step();
        check_val("flush_ack_no_ok", bus.iresp_ok, 64'd0);
        step();
        s_ack = 1'b1; s_adata = 64'h9999_AAAA_BBBB_CCCC;
        step();
        check_val("flush_then_d", bus.creq_addr, 64'h0000_0000_0000_3000);
        step();
        s_dv = 1'b0;
        step();

        // random traffic
        lat = 0;
        lat_on = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (m_iok || !s_iv) begin
                s_iv = ($urandom % 3) != 0;
                s_ia = rnd64() & ~64'd3;
            end
            s_fl = ($urandom % 8) == 0;
            if (s_fl) begin
                s_iv = ($urandom % 2) != 0;
                s_ia = rnd64() & ~64'd3;
            end
            if (m_dok || !s_dv) begin
                s_dv  = ($urandom % 3) != 0;
                s_da  = rnd64();
                s_dw  = ($urandom % 2) != 0;
                s_ds  = 3'($urandom_range(3, 0));
                s_dst = 8'($urandom);
                s_dwd = rnd64();
            end
            if (m_busy) begin
                if (!lat_on) begin
                    lat = int'($urandom_range(5, 0));
                    lat_on = 1'b1;
                end
                if (lat == 0) begin
                    s_ack = 1'b1;
                    s_adata = rnd64();
                    lat_on = 1'b0;
                end else begin
                    lat--;
                end
            end
            step();
        end

        // drain, then async reset in the middle of a store
        s_iv = 1'b0; s_dv = 1'b0;
        for (int k = 0; k < 20 && (m_busy || m_resp); k++) begin
            if (m_busy) s_ack = 1'b1;
            step();
        end
        s_dv = 1'b1; s_da = 64'h0000_0000_0000_7000; s_dw = 1'b1; s_ds = 3'd3;
        s_dst = 8'hF0; s_dwd = 64'hAABB_CCDD_EEFF_0011;
        step();
        step();
        check_val("store_held_wdata", bus.creq_wdata, 64'hAABB_CCDD_EEFF_0011);
        #2;
        resetn = 1'b0;
        s_dv = 1'b0;
        bus.dreq_valid = 1'b0;
        #1;
        check_val("async_rst_creq_valid", bus.creq_valid, 64'd0);
        check_val("async_rst_creq_addr", bus.creq_addr, 64'd0);
        model_reset();
        @(posedge clk);
        #2;
        resetn = 1'b1;
        for (int k = 0; k < 4; k++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
